// File: rtl/image_mem_dbuf_if.sv
// Port bundle between the image loader / convolution engine (master) and the
// ping-pong image memory (slave).
interface image_mem_dbuf_if #(
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 10
);
  localparam int BANK_NB   = DEPTH_NB / GROUP_NB;
  localparam int BANK_LG2  = (BANK_NB > 1) ? $clog2(BANK_NB) : 0;
  localparam int WR_AWIDTH = MEM_AWIDTH - BANK_LG2;

  // Handshake: a word/request moves on a clock edge where val & rdy are both
  // high; done pulses are only honoured while the matching rdy is high.
  logic                            wr_val;
  logic                            wr_rdy;
  logic [WR_AWIDTH-1:0]            wr_addr;
  logic [IMG_WIDTH*DEPTH_NB-1:0]   wr_data;
  logic                            wr_done;
  logic                            rd_val;
  logic                            rd_rdy;
  logic [MEM_AWIDTH-1:0]           rd_addr;
  logic                            rd_done;
  logic [GROUP_NB*IMG_WIDTH-1:0]   rd_data;
  logic                            rd_data_val;
  logic                            wr_page;
  logic                            rd_page;
  logic [1:0]                      full_nb;

  modport master (
    output wr_val, wr_addr, wr_data, wr_done, rd_val, rd_addr, rd_done,
    input  wr_rdy, rd_rdy, rd_data, rd_data_val, wr_page, rd_page, full_nb
  );

  modport slave (
    input  wr_val, wr_addr, wr_data, wr_done, rd_val, rd_addr, rd_done,
    output wr_rdy, rd_rdy, rd_data, rd_data_val, wr_page, rd_page, full_nb
  );
endinterface

// File: rtl/image_mem_dbuf.sv
// Ping-pong image memory: full-depth words written into one page while the
// other page is read back one column group per request (3-cycle latency).
module image_mem_dbuf #(
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  image_mem_dbuf_if.slave   bus
);
  localparam int BANK_NB   = DEPTH_NB / GROUP_NB;
  localparam int BANK_LG2  = (BANK_NB > 1) ? $clog2(BANK_NB) : 0;
  localparam int WR_AWIDTH = MEM_AWIDTH - BANK_LG2;
  localparam int COLW      = GROUP_NB * IMG_WIDTH;
  localparam int WRW       = IMG_WIDTH * DEPTH_NB;
  localparam int CW        = (BANK_LG2 > 0) ? BANK_LG2 : 1;
  localparam int WORDS     = 2 ** WR_AWIDTH;
  localparam bit PARAM_OK  = (BANK_NB >= 1) && (BANK_NB <= 64) &&
                             ((BANK_NB & (BANK_NB - 1)) == 0) &&
                             ((DEPTH_NB % GROUP_NB) == 0);

  logic [1:0]           full;
  logic                 wr_pg;
  logic                 rd_pg;
  logic                 wr_acc, wd_acc, rd_acc, rdn_acc;

  logic                 wr_v_q;
  logic                 wr_pg_q;
  logic [WR_AWIDTH-1:0] wr_addr_q;
  logic [WRW-1:0]       wr_data_q;

  logic                 rd_v1, rd_pg1;
  logic [WR_AWIDTH-1:0] rd_word1;
  logic [CW-1:0]        rd_col_in, rd_col1, rd_col2;
  logic                 rd_v2, rd_pg2;
  logic [BANK_LG2:0]    sel_idx;
  logic [COLW-1:0]      col_q [2*BANK_NB];
  logic [COLW-1:0]      rd_data_q;
  logic                 rd_val_q;

  assign bus.wr_rdy      = ~full[wr_pg];
  assign bus.rd_rdy      = full[rd_pg];
  assign bus.wr_page     = wr_pg;
  assign bus.rd_page     = rd_pg;
  assign bus.full_nb     = {1'b0, full[0]} + {1'b0, full[1]};
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_data_val = rd_val_q;

  assign wr_acc  = bus.wr_val  & ~full[wr_pg];
  assign wd_acc  = bus.wr_done & ~full[wr_pg];
  assign rd_acc  = bus.rd_val  & full[rd_pg];
  assign rdn_acc = bus.rd_done & full[rd_pg];

  generate
    if (BANK_NB > 1) begin : g_col
      assign rd_col_in = bus.rd_addr[BANK_LG2-1:0];
      assign sel_idx   = {rd_pg2, rd_col2};
    end else begin : g_nocol
      assign rd_col_in = '0;
      assign sel_idx   = rd_pg2;
    end
  endgenerate

  // wd_acc needs the writer page empty and rdn_acc needs the reader page full,
  // so the two updates never touch the same full bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 2'b00;
      wr_pg <= 1'b0;
      rd_pg <= 1'b0;
    end else begin
      if (wd_acc) begin
        full[wr_pg] <= 1'b1;
        wr_pg       <= ~wr_pg;
      end
      if (rdn_acc) begin
        full[rd_pg] <= 1'b0;
        rd_pg       <= ~rd_pg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_v_q    <= 1'b0;
      wr_pg_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_v1     <= 1'b0;
      rd_pg1    <= 1'b0;
      rd_word1  <= '0;
      rd_col1   <= '0;
      rd_v2     <= 1'b0;
      rd_pg2    <= 1'b0;
      rd_col2   <= '0;
      rd_val_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_v_q    <= wr_acc;
      wr_pg_q   <= wr_pg;
      wr_addr_q <= bus.wr_addr;
      wr_data_q <= bus.wr_data;
      rd_v1     <= rd_acc;
      rd_pg1    <= rd_pg;
      rd_word1  <= bus.rd_addr[MEM_AWIDTH-1:BANK_LG2];
      rd_col1   <= rd_col_in;
      rd_v2     <= rd_v1;
      rd_pg2    <= rd_pg1;
      rd_col2   <= rd_col1;
      rd_val_q  <= rd_v2;
      if (rd_v2) rd_data_q <= col_q[sel_idx];
    end
  end

  // One single-port RAM per page and column; write and read always hit
  // opposite pages, so each RAM sees at most one access per cycle.
  for (genvar p = 0; p < 2; p++) begin : g_page
    for (genvar b = 0; b < BANK_NB; b++) begin : g_bank
      logic [COLW-1:0] ram [WORDS];
      logic [COLW-1:0] rdq;
      logic            we, re;

      assign we = wr_v_q && (wr_pg_q == 1'(p));
      assign re = rd_v1  && (rd_pg1  == 1'(p));

      always_ff @(posedge clk) begin
        if (we)      ram[wr_addr_q] <= wr_data_q[b*COLW +: COLW];
        else if (re) rdq <= ram[rd_word1];
      end

      assign col_q[p*BANK_NB + b] = rdq;
    end
  end

  a_param_ok: assert property (@(posedge clk) disable iff (rst) PARAM_OK);
  a_page_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.wr_rdy && bus.rd_rdy && (wr_pg == rd_pg)));
endmodule

// File: tb/tb_image_mem_dbuf.sv
// Directed bench for the ping-pong image memory: fill/read pages, burst and
// concurrent traffic, full-page back-pressure, page reuse hazard, async reset.
module tb_image_mem_dbuf;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   val_cnt;
  int   cur_run;
  int   max_run;
  int   snap;
  logic [63:0] exp_q[$];

  image_mem_dbuf_if bus ();

  image_mem_dbuf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] colv(input logic [7:0] seed, input int w, input int b);
    return {seed, 8'(w), 40'h0, 8'(8'hA0 + b)};
  endfunction

  function automatic logic [255:0] word(input logic [7:0] seed, input int w);
    return {colv(seed, w, 3), colv(seed, w, 2), colv(seed, w, 1), colv(seed, w, 0)};
  endfunction

  // driver tasks: start just after a negedge, end on the next negedge
  task automatic wr_word(input int addr, input logic [255:0] data, input logic done);
    bus.wr_val  = 1'b1;
    bus.wr_addr = 8'(addr);
    bus.wr_data = data;
    bus.wr_done = done;
    @(negedge clk);
    bus.wr_val  = 1'b0;
    bus.wr_done = 1'b0;
  endtask

  task automatic wr_done_pulse();
    bus.wr_done = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b0;
  endtask

  task automatic rd_req(input int addr, input logic acc, input logic [63:0] data, input logic done);
    bus.rd_val  = 1'b1;
    bus.rd_addr = 10'(addr);
    bus.rd_done = done;
    if (acc) exp_q.push_back(data);
    @(negedge clk);
    bus.rd_val  = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: every rd_data_val must match the oldest expected read
  always @(negedge clk) begin
    if (bus.rd_data_val) begin
      val_cnt++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (exp_q.size() == 0) check("rd_spurious", 64'd1, 64'd0);
      else                   check("rd_data", bus.rd_data, exp_q.pop_front());
    end else begin
      cur_run = 0;
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; val_cnt = 0; cur_run = 0; max_run = 0;
    rst = 1'b1;
    bus.wr_val = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_done = 1'b0;
    bus.rd_val = 1'b0; bus.rd_addr = '0; bus.rd_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_full_nb", 64'(bus.full_nb), 64'd0);
    check("rst_wr_rdy", 64'(bus.wr_rdy), 64'd1);
    check("rst_rd_rdy", 64'(bus.rd_rdy), 64'd0);
    check("rst_pages", 64'({bus.wr_page, bus.rd_page}), 64'd0);
    check("rst_rd_val", 64'(bus.rd_data_val), 64'd0);
    check("rst_rd_data", bus.rd_data, 64'd0);

    // read on empty memory is ignored
    rd_req(3, 1'b0, 64'd0, 1'b0);
    repeat (4) @(negedge clk);
    check("empty_read_ignored", 64'(val_cnt), 64'd0);

    // test 1: fill page0 words 0..7, done with the last write
    for (int w = 0; w < 8; w++) wr_word(w, word(8'h11, w), w == 7);
    check("t1_full_nb", 64'(bus.full_nb), 64'd1);
    check("t1_rd_rdy", 64'(bus.rd_rdy), 64'd1);
    check("t1_wr_page", 64'(bus.wr_page), 64'd1);
    check("t1_rd_page", 64'(bus.rd_page), 64'd0);
    rd_req(22, 1'b1, colv(8'h11, 5, 2), 1'b0);
    check("t1_lat1", 64'(bus.rd_data_val), 64'd0);
    @(negedge clk);
    check("t1_lat2", 64'(bus.rd_data_val), 64'd0);
    @(negedge clk);
    check("t1_lat3", 64'(bus.rd_data_val), 64'd1);
    drain();

    // test 2: back-to-back burst
    max_run = 0;
    for (int b = 0; b < 4; b++) rd_req(20 + b, 1'b1, colv(8'h11, 5, b), 1'b0);
    drain();
    check("t2_burst_run", 64'(max_run), 64'd4);

    // test 3: fill page1 while streaming page0
    max_run = 0;
    fork
      for (int w = 0; w < 8; w++) wr_word(w, word(8'h22, w), 1'b0);
      for (int a = 0; a < 32; a++) rd_req(a, 1'b1, colv(8'h11, a / 4, a % 4), 1'b0);
    join
    drain();
    check("t3_stream_run", 64'(max_run), 64'd32);
    wr_done_pulse();
    check("t3_full_nb", 64'(bus.full_nb), 64'd2);
    check("t3_wr_rdy", 64'(bus.wr_rdy), 64'd0);
    check("t3_wr_page", 64'(bus.wr_page), 64'd0);

    // test 4/5: blocked write, rd_done with last read, then reuse write
    wr_word(5, word(8'h33, 5), 1'b0);
    rd_req(22, 1'b1, colv(8'h11, 5, 2), 1'b0);
    rd_req(21, 1'b1, colv(8'h11, 5, 1), 1'b1);
    check("t4_wr_rdy", 64'(bus.wr_rdy), 64'd1);
    check("t4_full_nb", 64'(bus.full_nb), 64'd1);
    check("t4_rd_page", 64'(bus.rd_page), 64'd1);
    wr_word(5, word(8'h33, 5), 1'b1);
    check("t5_full_nb", 64'(bus.full_nb), 64'd2);
    check("t5_wr_page", 64'(bus.wr_page), 64'd1);
    for (int a = 0; a < 32; a++) rd_req(a, 1'b1, colv(8'h22, a / 4, a % 4), a == 31);
    check("t5_rd_page", 64'(bus.rd_page), 64'd0);
    check("t5_full_nb2", 64'(bus.full_nb), 64'd1);
    for (int b = 0; b < 4; b++) rd_req(20 + b, 1'b1, colv(8'h33, 5, b), 1'b0);
    rd_req(24, 1'b1, colv(8'h11, 6, 0), 1'b0);
    drain();

    // test 6: async reset in the middle of a burst
    rd_req(20, 1'b1, colv(8'h33, 5, 0), 1'b0);
    rd_req(21, 1'b1, colv(8'h33, 5, 1), 1'b0);
    bus.rd_val  = 1'b1;
    bus.rd_addr = 10'd22;
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.rd_val = 1'b0;
    #1;
    check("t6_rd_val", 64'(bus.rd_data_val), 64'd0);
    check("t6_full_nb", 64'(bus.full_nb), 64'd0);
    check("t6_wr_rdy", 64'(bus.wr_rdy), 64'd1);
    check("t6_rd_rdy", 64'(bus.rd_rdy), 64'd0);
    exp_q.delete();
    snap = val_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_no_pulses", 64'(val_cnt), 64'(snap));
    check("t6_pages", 64'({bus.wr_page, bus.rd_page}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
